// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared definitions for the instruction fetch unit:
//     - fetch_state_e : 2-bit FSM state encoding (S_REQ/S_WAIT/S_HOLD/S_FAULT)
//     - INSTR_BYTES   : size of one instruction in bytes (PC alignment unit)
//     - RESET_PC_DEFAULT : default architectural PC after reset
//     - pc_is_aligned : helper returning 1 when a PC is instruction-aligned
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned ALIGN_BITS       = $clog2(INSTR_BYTES);
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  // A PC is usable only when its low ALIGN_BITS bits are zero.
  function automatic logic pc_is_aligned(input logic [63:0] pc);
    return (pc[ALIGN_BITS-1:0] == '0);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundles every non-clock/reset signal of the fetch unit.
//   master : the fetch unit itself
//   slave  : its environment (next-PC logic, instruction memory, decode)
//   Signals:
//     NextPC        slave->master  next PC, meaningful while InstrValid
//     CurrentPC     master->slave  architectural PC
//     IMemAddr      master->slave  fetch address (== CurrentPC)
//     IMemReqValid  master->slave  fetch request valid
//     IMemReqReady  slave->master  memory accepts request
//     IMemRespValid slave->master  one-cycle response pulse
//     IMemRespData  slave->master  fetched instruction word
//     Instr         master->slave  registered instruction for decode
//     InstrValid    master->slave  Instr/CurrentPC valid for decode
//     InstrReady    slave->master  decode retires the instruction
//     Misaligned    master->slave  sticky misaligned-NextPC fault
//     RetiredCount  master->slave  retired instruction count (wraps)
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
);

  logic [63:0]        NextPC;
  logic [63:0]        CurrentPC;
  logic [63:0]        IMemAddr;
  logic               IMemReqValid;
  logic               IMemReqReady;
  logic               IMemRespValid;
  logic [INSTR_W-1:0] IMemRespData;
  logic [INSTR_W-1:0] Instr;
  logic               InstrValid;
  logic               InstrReady;
  logic               Misaligned;
  logic [CNT_W-1:0]   RetiredCount;

  modport master (
    input  NextPC, IMemReqReady, IMemRespValid, IMemRespData, InstrReady,
    output CurrentPC, IMemAddr, IMemReqValid, Instr, InstrValid,
           Misaligned, RetiredCount
  );

  modport slave (
    output NextPC, IMemReqReady, IMemRespValid, IMemRespData, InstrReady,
    input  CurrentPC, IMemAddr, IMemReqValid, Instr, InstrValid,
           Misaligned, RetiredCount
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// ----------------------------------------------------------------------------
// fetch_pc_reg
//   64-bit architectural PC register.
//   Ports:
//     clk_i             clock
//     rst_i             synchronous active-high reset, loads RESET_PC
//     load_i            load next_pc_i into the PC this cycle
//     next_pc_i         candidate next PC
//     pc_o              current PC
//     next_misaligned_o next_pc_i is not instruction-aligned
// ----------------------------------------------------------------------------
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [63:0] next_pc_i,
  output logic [63:0] pc_o,
  output logic        next_misaligned_o
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = next_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o              = pc_q;
  assign next_misaligned_o = !pc_is_aligned(next_pc_i);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Holds the architectural PC, fetches the instruction at that PC from
//   instruction memory over a req/resp handshake, presents it to decode and
//   loads NextPC when decode retires it. A misaligned NextPC at retirement
//   parks the unit in a sticky fault state that only Reset leaves.
//   Ports:
//     CLK    clock, all state on the rising edge
//     Reset  synchronous active-high reset, dominates everything
//     fif    instruction_fetch_unit_if.master (PC, memory, decode signals)
//   Timing with a zero-wait memory: accept@T, response@T+1, InstrValid@T+2,
//   next request@T+3 when retired at T+2 (one instruction per 3 cycles).
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          INSTR_W  = 32,
  parameter int          CNT_W    = 32
) (
  input  logic                      CLK,
  input  logic                      Reset,
  instruction_fetch_unit_if.master  fif
);

  fetch_state_e       state_q;
  logic               req_vld_q;
  logic               instr_vld_q;
  logic               mis_q;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic [63:0]        pc;
  logic               next_mis;
  logic               retire;
  logic               pc_load;

  // Retirement is only possible while an instruction is being held;
  // InstrReady in any other state is ignored.
  assign retire  = (state_q == S_HOLD) && fif.InstrReady;
  assign pc_load = retire && !next_mis;
  assign cnt_d   = cnt_q + CNT_W'(1);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i             (CLK),
    .rst_i             (Reset),
    .load_i            (pc_load),
    .next_pc_i         (fif.NextPC),
    .pc_o              (pc),
    .next_misaligned_o (next_mis)
  );

  // Fetch FSM with registered handshake outputs. Reset lands in S_REQ with the
  // request deasserted; the first S_REQ cycle raises IMemReqValid, and a
  // request is only considered accepted once it is actually being driven.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_REQ;
      req_vld_q   <= 1'b0;
      instr_vld_q <= 1'b0;
      instr_q     <= '0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_vld_q && fif.IMemReqReady) begin
            req_vld_q <= 1'b0;
            state_q   <= S_WAIT;
          end else begin
            req_vld_q <= 1'b1;
          end
        end
        S_WAIT: begin
          // Response is sampled only here; no timeout by design.
          if (fif.IMemRespValid) begin
            instr_q     <= fif.IMemRespData;
            instr_vld_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (retire) begin
            instr_vld_q <= 1'b0;
            cnt_q       <= cnt_d;
            if (next_mis) begin
              mis_q   <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              req_vld_q <= 1'b1;
              state_q   <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          req_vld_q   <= 1'b0;
          instr_vld_q <= 1'b0;
        end
        default: begin
          state_q <= S_FAULT;
        end
      endcase
    end
  end

  assign fif.CurrentPC    = pc;
  assign fif.IMemAddr     = pc;
  assign fif.IMemReqValid = req_vld_q;
  assign fif.Instr        = instr_q;
  assign fif.InstrValid   = instr_vld_q;
  assign fif.Misaligned   = mis_q;
  assign fif.RetiredCount = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  instruction_fetch_unit_if #(.INSTR_W(32), .CNT_W(32)) fif ();

  instruction_fetch_unit #(
    .RESET_PC (64'h0),
    .INSTR_W  (32),
    .CNT_W    (32)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .fif   (fif)
  );

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint rise_cyc = 0;
  longint prev_rise = 0;

  // Reference model state: what the architecture says should be visible.
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;
  logic [31:0] m_instr;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    fif.IMemReqReady  = 1'b0;
    fif.IMemRespValid = 1'b0;
    fif.IMemRespData  = '0;
    fif.InstrReady    = 1'b0;
    fif.NextPC        = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_reqvld"}, 64'(fif.IMemReqValid), 64'd0);
    chk({tag, "_ivld"},   64'(fif.InstrValid),   64'd0);
    chk({tag, "_pc"},     fif.CurrentPC,         64'h0);
    chk({tag, "_instr"},  64'(fif.Instr),        64'd0);
    chk({tag, "_cnt"},    64'(fif.RetiredCount), 64'd0);
    chk({tag, "_mis"},    64'(fif.Misaligned),   64'd0);
  endtask

  // One reset cycle, then the first cycle after release (request raised).
  task automatic reset_dut(input string tag);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle_inputs();
    m_pc = 64'h0; m_cnt = '0; m_mis = 1'b0; m_instr = '0;
    check_reset_outputs(tag);
    step();
    chk({tag, "_first_req"},  64'(fif.IMemReqValid), 64'd1);
    chk({tag, "_first_addr"}, fif.IMemAddr,          m_pc);
  endtask

  // Drive one complete fetch transaction from S_REQ through retirement.
  task automatic do_fetch(input int rdy_dly, input int rsp_dly, input int hold_dly,
                          input logic [63:0] npc, input logic [31:0] data);
    chk("req_valid", 64'(fif.IMemReqValid), 64'd1);
    chk("req_addr",  fif.IMemAddr,          m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      fif.IMemReqReady  = 1'b0;
      fif.IMemRespValid = 1'($urandom);
      fif.IMemRespData  = $urandom;
      fif.InstrReady    = 1'($urandom);
      fif.NextPC        = {$urandom, $urandom};
      step();
      chk("req_held",       64'(fif.IMemReqValid), 64'd1);
      chk("addr_stable",    fif.IMemAddr,          m_pc);
      chk("instr_spur_req", 64'(fif.Instr),        64'(m_instr));
    end
    fif.IMemReqReady  = 1'b1;
    fif.IMemRespValid = 1'b0;
    step();
    fif.IMemReqReady = 1'b0;
    chk("wait_noreq", 64'(fif.IMemReqValid), 64'd0);
    chk("wait_novld", 64'(fif.InstrValid),   64'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      fif.IMemReqReady = 1'($urandom);
      fif.InstrReady   = 1'($urandom);
      step();
      chk("no_dup_req",  64'(fif.IMemReqValid), 64'd0);
      chk("wait_ivld",   64'(fif.InstrValid),   64'd0);
    end
    fif.IMemReqReady  = 1'b0;
    fif.InstrReady    = 1'b0;
    fif.IMemRespValid = 1'b1;
    fif.IMemRespData  = data;
    step();
    fif.IMemRespValid = 1'b0;
    fif.IMemRespData  = $urandom;
    m_instr  = data;
    rise_cyc = cyc;
    chk("ivld_set",  64'(fif.InstrValid), 64'd1);
    chk("instr_val", 64'(fif.Instr),      64'(m_instr));
    chk("hold_pc",   fif.CurrentPC,       m_pc);
    for (int i = 0; i < hold_dly; i++) begin
      fif.InstrReady    = 1'b0;
      fif.IMemRespValid = 1'($urandom);
      fif.IMemRespData  = $urandom;
      step();
      chk("hold_instr", 64'(fif.Instr),        64'(m_instr));
      chk("hold_ivld",  64'(fif.InstrValid),   64'd1);
      chk("hold_pc2",   fif.CurrentPC,         m_pc);
      chk("hold_cnt",   64'(fif.RetiredCount), 64'(m_cnt));
    end
    fif.IMemRespValid = 1'b0;
    fif.InstrReady    = 1'b1;
    fif.NextPC        = npc;
    step();
    fif.InstrReady = 1'b0;
    m_cnt = m_cnt + 32'd1;
    if (npc[1:0] == 2'b00) m_pc = npc;
    else                   m_mis = 1'b1;
    chk("ret_ivld_drop", 64'(fif.InstrValid),   64'd0);
    chk("ret_cnt",       64'(fif.RetiredCount), 64'(m_cnt));
    chk("ret_mis",       64'(fif.Misaligned),   64'(m_mis));
    chk("ret_pc",        fif.CurrentPC,         m_pc);
    chk("ret_next_req",  64'(fif.IMemReqValid), 64'(!m_mis));
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();

    // 1: straight-line fetch, zero-wait memory, 3-cycle spacing
    reset_dut("rst0");
    for (int i = 0; i < 4; i++) begin
      do_fetch(0, 0, 0, m_pc + 64'd4, $urandom);
      if (i > 0) chk("t1_spacing", 64'(rise_cyc - prev_rise), 64'd3);
      prev_rise = rise_cyc;
    end
    chk("t1_cnt4", 64'(fif.RetiredCount), 64'd4);
    chk("t1_pc",   fif.CurrentPC,         64'h10);

    // 3: branch at 0x10 to 0x100, then branch-to-self
    do_fetch(0, 0, 0, 64'h100, $urandom);
    chk("t3_branch", fif.IMemAddr, 64'h100);
    do_fetch(0, 0, 0, 64'h100, $urandom);
    chk("t3_self", fif.IMemAddr, 64'h100);

    // 2: slow request acceptance and delayed response
    do_fetch(5, 7, 0, 64'h100, $urandom);

    // 4: misaligned NextPC faults and parks the unit
    do_fetch(0, 0, 0, 64'h102, $urandom);
    for (int i = 0; i < 20; i++) begin
      fif.IMemReqReady  = 1'($urandom);
      fif.IMemRespValid = 1'($urandom);
      fif.IMemRespData  = $urandom;
      fif.InstrReady    = 1'($urandom);
      fif.NextPC        = {$urandom, $urandom} & ~64'h3;
      step();
      chk("t4_noreq", 64'(fif.IMemReqValid), 64'd0);
      chk("t4_novld", 64'(fif.InstrValid),   64'd0);
      chk("t4_mis",   64'(fif.Misaligned),   64'd1);
      chk("t4_pc",    fif.CurrentPC,         64'h100);
    end
    chk("t4_cnt", 64'(fif.RetiredCount), 64'(m_cnt));
    reset_dut("rst_fault");

    // 5a: reset while waiting for the response
    do_fetch(0, 0, 0, 64'h4, 32'h1234_5678);
    fif.IMemReqReady = 1'b1;
    step();
    fif.IMemReqReady = 1'b0;
    chk("t5_in_wait", 64'(fif.IMemReqValid), 64'd0);
    reset_dut("rst_wait");

    // 5b: reset while holding, with decode trying to retire
    do_fetch(0, 0, 0, 64'h8, $urandom);
    fif.IMemReqReady = 1'b1;
    step();
    fif.IMemReqReady  = 1'b0;
    fif.IMemRespValid = 1'b1;
    fif.IMemRespData  = 32'hDEAD_BEEF;
    step();
    fif.IMemRespValid = 1'b0;
    chk("t5_in_hold", 64'(fif.Instr), 64'hDEAD_BEEF);
    fif.InstrReady = 1'b1;
    fif.NextPC     = 64'h40;
    reset_dut("rst_hold");

    // 6: long hold, then wrap of the PC through the top of the address space
    do_fetch(0, 0, 10, 64'hFFFF_FFFF_FFFF_FFFC, $urandom);
    chk("t6_top", fif.IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(0, 0, 0, m_pc + 64'd4, $urandom);
    chk("t6_wrap",    fif.IMemAddr,        64'h0);
    chk("t6_nofault", 64'(fif.Misaligned), 64'd0);

    // Random fetch stream against the model
    for (int n = 0; n < 40; n++) begin
      logic [63:0] npc;
      case ($urandom_range(0, 3))
        0:       npc = {$urandom, $urandom} & ~64'h3;
        1:       npc = m_pc;
        default: npc = m_pc + 64'd4;
      endcase
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               npc, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
